// File: rtl/root_result_bcd.sv
// Converts one Q10.10 root result into packed BCD: 4 integer digits via double-dabble,
// FRAC_DIGITS truncated fraction digits via repeated multiply-by-10. One conversion in flight.
module root_result_bcd #(
    parameter int FRAC_DIGITS = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [19:0]                in_data,
    output logic                       busy,
    output logic                       drop_err,
    output logic                       out_valid,
    output logic [15:0]                out_int_bcd,
    output logic [4*FRAC_DIGITS-1:0]   out_frac_bcd
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INT  = 2'd1,
        ST_FRAC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAST_FRAC = 4'(FRAC_DIGITS - 1);

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = b[4*i +: 4];
            end
        end
        return r;
    endfunction

    state_t                     state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic [9:0]                 shreg_q, shreg_d;
    logic [15:0]                bcd_q, bcd_d;
    logic [9:0]                 acc_q, acc_d;
    logic [15:0]                frac_q, frac_d;
    logic                       drop_err_q, drop_err_d;
    logic                       out_valid_q, out_valid_d;
    logic [15:0]                out_int_q, out_int_d;
    logic [4*FRAC_DIGITS-1:0]   out_frac_q, out_frac_d;
    logic [13:0]                prod_s;
    logic [15:0]                adj_s;

    // Next-state and datapath for the conversion sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        bcd_d       = bcd_q;
        acc_d       = acc_q;
        frac_d      = frac_q;
        out_valid_d = 1'b0;
        out_int_d   = 16'd0;
        out_frac_d  = '0;
        drop_err_d  = in_valid && (state_q != ST_IDLE);
        prod_s      = 14'd0;
        adj_s       = 16'd0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shreg_d = in_data[19:10];
                    acc_d   = in_data[9:0];
                    bcd_d   = 16'd0;
                    frac_d  = 16'd0;
                    cnt_d   = 4'd0;
                    state_d = ST_INT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INT: begin
                adj_s            = bcd_adjust(bcd_q);
                {bcd_d, shreg_d} = {adj_s[14:0], shreg_q, 1'b0};
                if (cnt_q == 4'd9) begin
                    cnt_d   = 4'd0;
                    state_d = ST_FRAC;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_FRAC: begin
                // Integer part of acc*10/1024 is the next decimal digit; the remainder carries on.
                prod_s = {4'd0, acc_q} * 14'd10;
                frac_d = {frac_q[11:0], prod_s[13:10]};
                acc_d  = prod_s[9:0];
                if (cnt_q == LAST_FRAC) begin
                    cnt_d   = 4'd0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                // DONE lasts two cycles: load the outputs, then hold busy through the strobe cycle.
                if (out_valid_q) begin
                    state_d = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                    out_int_d   = bcd_q;
                    out_frac_d  = frac_q[4*FRAC_DIGITS-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            shreg_q     <= 10'd0;
            bcd_q       <= 16'd0;
            acc_q       <= 10'd0;
            frac_q      <= 16'd0;
            drop_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_int_q   <= 16'd0;
            out_frac_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            bcd_q       <= bcd_d;
            acc_q       <= acc_d;
            frac_q      <= frac_d;
            drop_err_q  <= drop_err_d;
            out_valid_q <= out_valid_d;
            out_int_q   <= out_int_d;
            out_frac_q  <= out_frac_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign drop_err     = drop_err_q;
    assign out_valid    = out_valid_q;
    assign out_int_bcd  = out_int_q;
    assign out_frac_bcd = out_frac_q;

endmodule
